// File: rtl/snn_rom_pkg.sv
// Shared definitions for the ROM burst read arbiter.
// Holds the default width constants and the read-FSM state encoding.
package snn_rom_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_LEN_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// Ports:
//   req      - request bits of requester 1/0
//   last_gnt - index of the requester granted most recently
//   winner   - one-hot winner, all-zero when no request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] winner
);

  always_comb begin
    winner = '0;
    unique case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      // Contention: the requester that did not win last time goes first.
      2'b11:   winner = last_gnt ? 2'b01 : 2'b10;
      default: winner = '0;
    endcase
  end

endmodule

// File: rtl/rom_rd_arb.sv
// Burst read arbiter in front of a 1-cycle-latency synchronous ROM.
// Two requesters each ask for a burst (start address + length). One burst is
// accepted at a time in IDLE, its addresses are issued contiguously in ISSUE,
// and DRAIN covers the ROM read latency of the final word.
// Ports:
//   clk, rst_n               - clock, asynchronous active-low reset
//   req[1:0]                 - burst requests, held until matching gnt bit
//   start_addr0/1, len0/1    - burst descriptors (len 0 means 2**LEN_WIDTH)
//   gnt[1:0]                 - one-cycle one-hot grant pulse
//   rom_addr / rom_q         - ROM address out, registered ROM data in
//   rd_data/valid/id/last    - returned word stream
//   busy                     - FSM not idle
module rom_rd_arb
  import snn_rom_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [ADDR_WIDTH-1:0] start_addr0,
  input  logic [ADDR_WIDTH-1:0] start_addr1,
  input  logic [LEN_WIDTH-1:0]  len0,
  input  logic [LEN_WIDTH-1:0]  len1,
  output logic [1:0]            gnt,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic                  rd_last,
  output logic                  busy
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [LEN_WIDTH:0]    remain_q, remain_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  owner_q, owner_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  rd_valid_q, rd_id_q, rd_last_q;
  logic [1:0]            win;
  logic                  issuing;
  logic                  final_addr;

  rr_arb2 u_arb (
    .req      (req),
    .last_gnt (last_gnt_q),
    .winner   (win)
  );

  assign issuing    = (state_q == ISSUE);
  assign final_addr = issuing && (remain_q == (LEN_WIDTH + 1)'(1));

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    remain_d   = remain_q;
    last_gnt_d = last_gnt_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = ISSUE;
          gnt_d      = win;
          owner_d    = win[1];
          last_gnt_d = win[1];
          // Zero length gets the extra top bit set, i.e. 2**LEN_WIDTH words.
          if (win[1]) begin
            cur_addr_d = start_addr1;
            remain_d   = {len1 == '0, len1};
          end else begin
            cur_addr_d = start_addr0;
            remain_d   = {len0 == '0, len0};
          end
        end
      end
      ISSUE: begin
        cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
        remain_d   = remain_q - (LEN_WIDTH + 1)'(1);
        if (final_addr) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      addr_hold_q <= '0;
      remain_q    <= '0;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      gnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_id_q     <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remain_q    <= remain_d;
      last_gnt_q  <= last_gnt_d;
      owner_q     <= owner_d;
      gnt_q       <= gnt_d;
      if (issuing) addr_hold_q <= cur_addr_q;
      rd_valid_q  <= issuing;
      rd_id_q     <= owner_q;
      rd_last_q   <= final_addr;
    end
  end

  // cur_addr runs one past the last word after ISSUE, so the ROM address is
  // held from a separate copy of the last issued address.
  assign rom_addr = issuing ? cur_addr_q : addr_hold_q;
  assign gnt      = gnt_q;
  assign rd_data  = rom_q;
  assign rd_valid = rd_valid_q;
  assign rd_id    = rd_id_q;
  assign rd_last  = rd_last_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_rd_arb.sv
module tb_rom_rd_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [9:0] start_addr0, start_addr1;
  logic [7:0] len0, len1;
  logic [1:0] gnt;
  logic [9:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] rd_data;
  logic       rd_valid, rd_id, rd_last, busy;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  rom_rd_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LEN_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .start_addr0 (start_addr0),
    .start_addr1 (start_addr1),
    .len0        (len0),
    .len1        (len1),
    .gnt         (gnt),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_id       (rd_id),
    .rd_last     (rd_last),
    .busy        (busy)
  );

  function automatic logic [7:0] rom_val(input logic [9:0] a);
    return a[7:0] ^ {a[9:8], a[9:8], a[9:8], a[9:8]} ^ 8'h5A;
  endfunction

  // Synchronous ROM model, one cycle of latency.
  always_ff @(posedge clk) rom_q <= rom_val(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge in IDLE with req already driven; expects gnt next cycle.
  task automatic wait_gnt(input int id, input logic [9:0] addr);
    int n;
    n = 1;
    @(negedge clk);
    while (gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gnt", gnt, (id == 1) ? 2'b10 : 2'b01);
    chk("gnt_latency", n, 1);
    chk("first_rom_addr", rom_addr, addr);
    chk("busy_at_gnt", busy, 1);
    req[id] = 1'b0;
  endtask

  // Called at the gnt negedge; checks the word stream and the IDLE cycle after.
  task automatic collect(input int id, input logic [9:0] addr, input int words, input bit pulse1);
    logic [9:0] ea;
    for (int i = 0; i < words; i++) begin
      @(negedge clk);
      if (pulse1 && i == 0) req[1] = 1'b1;
      if (pulse1 && i == 2) req[1] = 1'b0;
      ea = (i + 1 < words) ? addr + 10'(i + 1) : addr + 10'(words - 1);
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, rom_val(addr + 10'(i)));
      chk("rd_id", rd_id, id);
      chk("rd_last", rd_last, (i == words - 1));
      chk("rom_addr", rom_addr, ea);
      chk("busy", busy, 1);
    end
    @(negedge clk);
    chk("rd_valid_after", rd_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  typedef struct {
    logic [1:0] set_req;
    logic [9:0] sa0;
    logic [7:0] l0;
    logic [9:0] sa1;
    logic [7:0] l1;
    int         id;
    logic [9:0] addr;
    int         words;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    vecs[0] = '{2'b11, 10'h100, 8'd2, 10'h200, 8'd2, 0, 10'h100, 2};
    vecs[1] = '{2'b00, 10'h100, 8'd2, 10'h200, 8'd2, 1, 10'h200, 2};
    vecs[2] = '{2'b11, 10'h100, 8'd2, 10'h200, 8'd2, 0, 10'h100, 2};
    vecs[3] = '{2'b00, 10'h100, 8'd2, 10'h200, 8'd2, 1, 10'h200, 2};
    vecs[4] = '{2'b01, 10'h010, 8'd3, 10'h200, 8'd2, 0, 10'h010, 3};
    vecs[5] = '{2'b10, 10'h010, 8'd3, 10'h3FE, 8'd4, 1, 10'h3FE, 4};
    vecs[6] = '{2'b01, 10'h050, 8'd1, 10'h3FE, 8'd4, 0, 10'h050, 1};
    vecs[7] = '{2'b01, 10'h3F0, 8'd0, 10'h3FE, 8'd4, 0, 10'h3F0, 256};
    vecs[8] = '{2'b11, 10'h060, 8'd2, 10'h070, 8'd3, 1, 10'h070, 3};
    vecs[9] = '{2'b00, 10'h060, 8'd2, 10'h070, 8'd3, 0, 10'h060, 2};

    rst_n = 1'b0;
    req = '0;
    start_addr0 = '0;
    start_addr1 = '0;
    len0 = '0;
    len1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_id", rd_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rom_addr", rom_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      start_addr0 = vecs[v].sa0;
      len0        = vecs[v].l0;
      start_addr1 = vecs[v].sa1;
      len1        = vecs[v].l1;
      req         = req | vecs[v].set_req;
      wait_gnt(vecs[v].id, vecs[v].addr);
      collect(vecs[v].id, vecs[v].addr, vecs[v].words, 1'b0);
    end

    // A request pulsing high only while busy must not be granted later.
    start_addr0 = 10'h080;
    len0 = 8'd4;
    req = 2'b01;
    wait_gnt(0, 10'h080);
    collect(0, 10'h080, 4, 1'b1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt != 2'b00 || rd_valid) cnt++;
    end
    chk("ignored_req_no_grant", cnt, 0);

    // Reset during the second word of a five-word burst from requester 1.
    start_addr1 = 10'h020;
    len1 = 8'd5;
    req = 2'b10;
    wait_gnt(1, 10'h020);
    @(negedge clk);
    chk("pre_rst_valid", rd_valid, 1);
    @(negedge clk);
    chk("pre_rst_id", rd_id, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_rd_last", rd_last, 0);
    chk("midrst_rd_id", rd_id, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd_valid || busy) cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rd_valid || busy || gnt != 2'b00) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    // Round-robin pointer is back to favouring requester 0 after reset.
    start_addr0 = 10'h0A0;
    len0 = 8'd2;
    start_addr1 = 10'h0B0;
    len1 = 8'd1;
    req = 2'b11;
    wait_gnt(0, 10'h0A0);
    collect(0, 10'h0A0, 2, 1'b0);
    wait_gnt(1, 10'h0B0);
    collect(1, 10'h0B0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_rd_arb.md
ROM_RD_ARB -- requirements
Module: rom_rd_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 8, ROM word width.
REQ-002 Parameter ADDR_WIDTH, default 10, ROM address width.
REQ-003 Parameter LEN_WIDTH, default 8, burst length field width.
REQ-004 clk  in  1  system clock, 50 MHz, all state on rising edge.
REQ-005 rst_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-006 req  in  2  per-requester burst request, held high until matching gnt bit seen.
REQ-007 start_addr0, start_addr1  in  ADDR_WIDTH  first word address of requester 0/1 burst.
REQ-008 len0, len1  in  LEN_WIDTH  burst word count of requester 0/1; 0 encodes 2**LEN_WIDTH.
REQ-009 gnt  out  2  one-hot, one-cycle pulse; burst accepted and its start_addr/len sampled.
REQ-010 rom_addr  out  ADDR_WIDTH  address to the 1-cycle-latency synchronous ROM.
REQ-011 rom_q  in  DATA_WIDTH  ROM registered read data.
REQ-012 rd_data  out  DATA_WIDTH  returned word, equal to rom_q, meaningful only while rd_valid.
REQ-013 rd_valid  out  1  rd_data valid this cycle.
REQ-014 rd_id  out  1  owning requester of current rd_data.
REQ-015 rd_last  out  1  high with final word of a burst.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, DRAIN; arbitration SHALL occur only in IDLE.
REQ-018 IDLE with any req bit high at a rising edge: select winner, latch its start_addr/len into cur_addr/remain (LEN_WIDTH+1 bits), register gnt winner bit, go ISSUE.
REQ-019 Round robin: single req wins; both high -> requester not granted last wins; last_gnt resets to 1 so requester 0 wins first contention.
REQ-020 ISSUE: rom_addr = cur_addr each cycle, cur_addr increments by 1, remain decrements by 1; first ISSUE cycle drives start_addr and coincides with gnt pulse.
REQ-021 ISSUE -> DRAIN when the cycle drives the final address (remain == 1); DRAIN -> IDLE unconditionally after one cycle.
REQ-022 rd_valid, rd_id, rd_last SHALL be registered copies of (issuing, owner, final-address) from the previous cycle; rd_data = rom_q combinationally.
REQ-023 Latency: req sampled at edge T -> gnt and first rom_addr in cycle T+1 -> first rd_valid in T+2; words contiguous, one per cycle, no gaps within a burst.
REQ-024 cur_addr SHALL wrap modulo 2**ADDR_WIDTH (0x3FF -> 0x000 at default).
REQ-025 len 0 SHALL issue exactly 2**LEN_WIDTH words.
REQ-026 rom_addr SHALL hold its last value outside ISSUE.
REQ-027 req changes outside IDLE SHALL be ignored; a request still high when IDLE is re-entered is arbitrated normally.
REQ-028 Minimum gap between bursts: one IDLE cycle between rd_last of one burst and next gnt.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, gnt=0, rd_valid=0, rd_last=0, rd_id=0, busy=0, rom_addr=0, cur_addr=0, remain=0, last_gnt=1.
REQ-030 Reset mid-burst SHALL abandon the burst; no rd_valid until a new grant after release.

Structure
REQ-031 Shared package snn_rom_pkg SHALL hold the FSM state enum and default DATA/ADDR/LEN width constants.
REQ-032 Two-way round-robin pick SHALL be sub-module rr_arb2 (inputs req, last_gnt; output one-hot winner).

Verification
REQ-033 req=01, start_addr0=0x010, len0=3 -> gnt=01 at T+1, rom_addr 0x010,0x011,0x012, rd_valid T+2..T+4, rd_id=0, rd_last at T+4 only.
REQ-034 req=11 from reset, len0=len1=2 -> requester 0 first, then requester 1 after one IDLE cycle; repeat -> 0 then 1 alternate.
REQ-035 start_addr1=0x3FE, len1=4 -> rom_addr 0x3FE,0x3FF,0x000,0x001; rd_data matches ROM contents.
REQ-036 len0=0 -> exactly 256 rd_valid cycles, single rd_last on 256th.
REQ-037 rst_n low during 2nd word of 5-word burst -> outputs at reset values immediately, no further rd_valid; next req granted normally.
REQ-038 len0=1 -> gnt, one word, busy high exactly 2 cycles (ISSUE, DRAIN).
